nn_sequencer: RTL and testbench
===============================

Name: nn_sequencer

Overview:
- Programmable instruction sequencer that drives the 25-bit instruction bus of the 2x2 neural-network datapath top level.
- Holds a small program of sequencer entries, loaded by a host through a write port.
- On start, it steps through the program and issues one datapath instruction per cycle, with inserted delays, waits on the datapath's output valid pulses, and one level of looping.
- Sits between the host/testbench and the nn top level; its only connection into nn is the instruction bus plus the two output valids.

Parameters:
DEPTH, 32, program memory entries (power of 2)
ADDR_W, 5, log2(DEPTH)
TIMEOUT, 1024, max cycles a WAIT entry may stall before error

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin execution at pc=0; honoured only in IDLE
abort  in  1  return to IDLE next cycle; instruction=0; no done pulse
prog_we  in  1  program write strobe; ignored while busy
prog_addr  in  ADDR_W  program write address
prog_wdata  in  36  entry: [24:0] payload, [27:25] op, [35:28] arg
nn_valid_out_1  in  1  datapath output valid, column 1
nn_valid_out_2  in  1  datapath output valid, column 2
instruction  out  25  registered instruction to the datapath
pc  out  ADDR_W  current program counter
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on normal completion
error  out  1  sticky WAIT timeout flag; cleared by rst or start

Behaviour:
- Reset: instruction=0, pc=0, busy=0, done=0, error=0, loop_rem=0, loop_active=0, state=IDLE. Program memory contents are not reset.
- Program memory: register array. Writes take effect the cycle after prog_we. Reads are combinational from mem[pc].
- The op field is defined in the package:
  - OP_ISSUE=0
  - OP_DELAY=1
  - OP_WAIT=2
  - OP_LOOP=3
  - OP_HALT=4
  - Codes 5-7 execute as OP_HALT.
- States: IDLE, EXEC, DELAY, WAIT.
- IDLE:
  - instruction=0.
  - start at cycle t: pc<=0, error<=0, state<=EXEC.
  - The first entry's effect is visible at instruction at t+2 (EXEC decodes at t+1, registers at t+2).
- EXEC, one entry per cycle:
  - ISSUE: instruction<=payload for exactly one cycle; pc++.
  - DELAY: instruction<=0; cnt<=max(arg,1)-1. If cnt is 0, pc++; otherwise go to DELAY, which decrements cnt each cycle and does pc++ with return to EXEC when cnt reaches 0. Total zero-instruction cycles = max(arg,1).
  - WAIT: instruction<=payload, held every cycle in WAIT.
    - Each cycle in which nn_valid_out_2=1 increments vcnt.
    - Exit when vcnt reaches max(arg,1): instruction<=0 on the exit cycle, pc++, back to EXEC.
    - nn_valid_out_1 is counted only when arg[7]=1: that mode counts cycles where either valid is high, and the threshold is arg[6:0].
    - Timeout counter is reset on entry. If it reaches TIMEOUT: error<=1, instruction<=0, state<=IDLE, no done.
  - LOOP: target = payload[ADDR_W-1:0].
    - If !loop_active and arg==0: pc++.
    - If !loop_active and arg!=0: loop_active<=1, loop_rem<=arg-1, pc<=target.
    - If loop_active and loop_rem!=0: loop_rem--, pc<=target.
    - If loop_active and loop_rem==0: loop_active<=0, pc++.
    - Net effect: the body executes arg+1 times. Nested LOOP entries are not supported; an inner LOOP shares the same counter.
    - instruction<=0 during LOOP.
  - HALT: instruction<=0, done pulse, state<=IDLE, pc holds.
- pc wrap: executing a non-branching entry at pc=DEPTH-1 ends the program. This is an implicit HALT with a done pulse; pc holds at DEPTH-1.
- Simultaneous events:
  - abort beats every other event.
  - start while busy is ignored.
  - prog_we while busy is dropped.
  - rst beats abort.
- Reset mid-operation: all outputs return to their reset values on the next edge.

Decomposition:
- Package nn_seq_pkg:
  - op enum: seq_op_t with the five codes above.
  - Entry field widths: PAYLOAD_W=25, OP_W=3, ARG_W=8, ENTRY_W=36.
  - Packed struct seq_entry_t.
  - State enum.
- Sub-module nn_seq_prog_mem: register-array memory with write port and combinational read.
- The FSM lives in the top of this block.

Test Plan:
- Program: [ISSUE 0x0000AB], [ISSUE 0x0000CD], [HALT]; pulse start at cycle 0. Required: instruction=0x0000AB at cycle 2, 0x0000CD at cycle 3, 0 at cycle 4; done pulses at cycle 4; busy falls at cycle 5.
- Program: [DELAY arg=3], [ISSUE 0x1], [HALT]. Required: instruction=0 for 3 cycles, then 0x1 for one cycle. arg=0 gives 1 delay cycle.
- Program: [WAIT payload=0x15 arg=2], [HALT]; drive nn_valid_out_2 high at two non-adjacent cycles. Required: 0x15 held until the cycle of the second pulse; pc advances; done asserts; error=0.
- Same WAIT with no valid pulses and TIMEOUT=16. Required: error=1 after 16 WAIT cycles; return to IDLE; no done pulse.
- Program: [ISSUE 0x2], [LOOP target=0 arg=2], [HALT]. Required: 0x2 issued exactly 3 times; loop_active=0 at HALT.
- Reset and abort checks:
  - Assert abort mid-DELAY: instruction=0 and busy=0 next cycle; done stays 0.
  - Assert rst mid-WAIT: all outputs return to their reset values.
  - prog_we while busy: memory is unchanged on readback.

Source files
------------

// File: rtl/nn_seq_pkg.sv
// Shared types for the nn instruction sequencer: entry layout, opcodes and FSM states.
package nn_seq_pkg;

    localparam int unsigned PAYLOAD_W = 25;
    localparam int unsigned OP_W      = 3;
    localparam int unsigned ARG_W     = 8;
    localparam int unsigned ENTRY_W   = PAYLOAD_W + OP_W + ARG_W;

    // Opcodes; 5..7 are not listed and behave as OP_HALT.
    typedef enum logic [OP_W-1:0] {
        OP_ISSUE = 3'd0,
        OP_DELAY = 3'd1,
        OP_WAIT  = 3'd2,
        OP_LOOP  = 3'd3,
        OP_HALT  = 3'd4
    } seq_op_t;

    // Program entry: [35:28] arg, [27:25] op, [24:0] payload.
    typedef struct packed {
        logic [ARG_W-1:0]     arg;
        logic [OP_W-1:0]      op;
        logic [PAYLOAD_W-1:0] payload;
    } seq_entry_t;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StDelay,
        StWait
    } seq_state_t;

    // Counts of zero are treated as one throughout the sequencer.
    function automatic logic [ARG_W-1:0] at_least_one(input logic [ARG_W-1:0] v);
        return (v == '0) ? ARG_W'(1) : v;
    endfunction

endpackage

// File: rtl/nn_seq_prog_mem.sv
// Program store for the sequencer: register array, one write port, combinational read.
module nn_seq_prog_mem #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned WIDTH  = 36
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents are deliberately not reset; the host reloads the program as needed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/nn_sequencer.sv
// Programmable sequencer that drives the 25-bit instruction bus of the nn datapath.
// Steps through a host-loaded program issuing payloads, delays, valid-count waits
// and a single level of looping.
module nn_sequencer
    import nn_seq_pkg::*;
#(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 prog_we,
    input  logic [ADDR_W-1:0]    prog_addr,
    input  logic [ENTRY_W-1:0]   prog_wdata,
    input  logic                 nn_valid_out_1,
    input  logic                 nn_valid_out_2,
    output logic [PAYLOAD_W-1:0] instruction,
    output logic [ADDR_W-1:0]    pc,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

    seq_state_t           state_q;
    logic [PAYLOAD_W-1:0] instr_q;
    logic [ADDR_W-1:0]    pc_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 error_q;
    logic [ARG_W-1:0]     cnt_q;
    logic [ARG_W-1:0]     vcnt_q;
    logic [TCNT_W-1:0]    tcnt_q;
    logic [ARG_W-1:0]     loop_rem_q;
    logic                 loop_active_q;

    logic [ENTRY_W-1:0]   mem_rdata;
    logic                 mem_we;

    seq_entry_t           cur;
    seq_op_t              op_dec;
    logic                 at_last;
    logic [ADDR_W-1:0]    pc_adv;
    seq_state_t           st_adv;
    logic [ADDR_W-1:0]    loop_tgt;
    logic [ARG_W-1:0]     wait_thr;
    logic                 wait_hit;
    logic                 wait_done;
    logic                 wait_tmo;

    // The program can only change while the sequencer is fully idle.
    assign mem_we = prog_we && (state_q == StIdle) && !busy_q;

    nn_seq_prog_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (ENTRY_W)
    ) u_prog_mem (
        .clk    (clk),
        .we     (mem_we),
        .waddr  (prog_addr),
        .wdata  (prog_wdata),
        .raddr  (pc_q),
        .rdata  (mem_rdata)
    );

    // Decode the current entry and precompute the shared "advance pc" outcome.
    always_comb begin
        cur      = seq_entry_t'(mem_rdata);
        op_dec   = (cur.op > 3'd4) ? OP_HALT : seq_op_t'(cur.op);
        at_last  = (pc_q == ADDR_W'(DEPTH - 1));
        // Stepping past the last entry ends the program in place.
        pc_adv   = at_last ? pc_q : pc_q + ADDR_W'(1);
        st_adv   = at_last ? StIdle : StExec;
        loop_tgt = cur.payload[ADDR_W-1:0];
        if (cur.arg[7]) begin
            // Either-column mode: threshold lives in the low seven bits.
            wait_thr = at_least_one({1'b0, cur.arg[6:0]});
            wait_hit = nn_valid_out_1 || nn_valid_out_2;
        end else begin
            wait_thr = at_least_one(cur.arg);
            wait_hit = nn_valid_out_2;
        end
        wait_done = wait_hit && ((vcnt_q + ARG_W'(1)) >= wait_thr);
        wait_tmo  = (tcnt_q == TCNT_W'(TIMEOUT - 1));
    end

    // Sequencer FSM with registered instruction, pc and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            instr_q       <= '0;
            pc_q          <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            cnt_q         <= '0;
            vcnt_q        <= '0;
            tcnt_q        <= '0;
            loop_rem_q    <= '0;
            loop_active_q <= 1'b0;
        end else if (abort) begin
            state_q       <= StIdle;
            instr_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            loop_rem_q    <= '0;
            loop_active_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    instr_q <= '0;
                    // busy stays up through the cycle after the FSM returns to idle
                    busy_q  <= start;
                    if (start) begin
                        pc_q          <= '0;
                        error_q       <= 1'b0;
                        loop_rem_q    <= '0;
                        loop_active_q <= 1'b0;
                        state_q       <= StExec;
                    end
                end

                StExec: begin
                    busy_q <= 1'b1;
                    case (op_dec)
                        OP_ISSUE: begin
                            instr_q <= cur.payload;
                            pc_q    <= pc_adv;
                            done_q  <= at_last;
                            state_q <= st_adv;
                        end
                        OP_DELAY: begin
                            instr_q <= '0;
                            if (cur.arg <= ARG_W'(1)) begin
                                pc_q    <= pc_adv;
                                done_q  <= at_last;
                                state_q <= st_adv;
                            end else begin
                                cnt_q   <= cur.arg - ARG_W'(1);
                                state_q <= StDelay;
                            end
                        end
                        OP_WAIT: begin
                            instr_q <= cur.payload;
                            vcnt_q  <= '0;
                            tcnt_q  <= '0;
                            state_q <= StWait;
                        end
                        OP_LOOP: begin
                            instr_q <= '0;
                            if (!loop_active_q && (cur.arg != '0)) begin
                                loop_active_q <= 1'b1;
                                loop_rem_q    <= cur.arg - ARG_W'(1);
                                pc_q          <= loop_tgt;
                            end else if (loop_active_q && (loop_rem_q != '0)) begin
                                loop_rem_q <= loop_rem_q - ARG_W'(1);
                                pc_q       <= loop_tgt;
                            end else begin
                                loop_active_q <= 1'b0;
                                pc_q          <= pc_adv;
                                done_q        <= at_last;
                                state_q       <= st_adv;
                            end
                        end
                        default: begin
                            instr_q <= '0;
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end
                    endcase
                end

                StDelay: begin
                    busy_q  <= 1'b1;
                    instr_q <= '0;
                    cnt_q   <= cnt_q - ARG_W'(1);
                    if (cnt_q == ARG_W'(1)) begin
                        pc_q    <= pc_adv;
                        done_q  <= at_last;
                        state_q <= st_adv;
                    end
                end

                StWait: begin
                    busy_q <= 1'b1;
                    // A qualifying valid on the last allowed cycle still counts as success.
                    if (wait_done) begin
                        instr_q <= '0;
                        pc_q    <= pc_adv;
                        done_q  <= at_last;
                        state_q <= st_adv;
                    end else if (wait_tmo) begin
                        error_q <= 1'b1;
                        instr_q <= '0;
                        state_q <= StIdle;
                    end else begin
                        instr_q <= cur.payload;
                        tcnt_q  <= tcnt_q + TCNT_W'(1);
                        if (wait_hit) begin
                            vcnt_q <= vcnt_q + ARG_W'(1);
                        end
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign instruction = instr_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule

// File: tb/tb_nn_sequencer.sv
// Self-checking bench for nn_sequencer: directed and random programs against an
// instruction-level interpreter of the program semantics.
module tb_nn_sequencer;
    import nn_seq_pkg::*;

    localparam int unsigned DEPTH   = 32;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned TIMEOUT = 16;
    localparam int          MAXC    = 1024;

    logic                 clk = 1'b0;
    logic                 rst, start, abort, prog_we, valid_1, valid_2;
    logic [ADDR_W-1:0]    prog_addr;
    logic [ENTRY_W-1:0]   prog_wdata;
    logic [PAYLOAD_W-1:0] instruction;
    logic [ADDR_W-1:0]    pc;
    logic                 busy, done, error;

    int n_pass   = 0;
    int n_checks = 0;

    logic [ENTRY_W-1:0]   prog [DEPTH];
    bit                   vs1 [MAXC];
    bit                   vs2 [MAXC];
    logic [PAYLOAD_W-1:0] exp_instr [MAXC];
    int                   exp_done_cyc, exp_end, exp_pc;
    bit                   exp_err, exp_la;

    always #5 clk = ~clk;

    nn_sequencer #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .prog_we        (prog_we),
        .prog_addr      (prog_addr),
        .prog_wdata     (prog_wdata),
        .nn_valid_out_1 (valid_1),
        .nn_valid_out_2 (valid_2),
        .instruction    (instruction),
        .pc             (pc),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [ENTRY_W-1:0] mk(input int op, input int arg,
                                              input logic [PAYLOAD_W-1:0] pl);
        return {arg[7:0], op[2:0], pl};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        for (int i = 0; i < int'(DEPTH); i++) prog[i] = mk(4, 0, '0);
        for (int c = 0; c < MAXC; c++) begin
            vs1[c] = 1'b0;
            vs2[c] = 1'b0;
        end
    endtask

    task automatic load_all();
        for (int i = 0; i < int'(DEPTH); i++) begin
            prog_we    = 1'b1;
            prog_addr  = ADDR_W'(i);
            prog_wdata = prog[i];
            step();
        end
        prog_we = 1'b0;
    endtask

    // Interpreter: entry decoded at cycle d shows its effect on instruction at d+1.
    task automatic model();
        int  d   = 1;
        int  p   = 0;
        int  rem = 0;
        bit  la  = 1'b0;
        bit  fin = 1'b0;
        for (int c = 0; c < MAXC; c++) exp_instr[c] = '0;
        exp_done_cyc = -1;
        exp_err      = 1'b0;
        exp_end      = 0;
        while (!fin) begin
            int op, arg, nd, thr, cnt, w;
            bit adv, a7;
            logic [PAYLOAD_W-1:0] pl;
            op  = int'(prog[p][27:25]);
            arg = int'(prog[p][35:28]);
            pl  = prog[p][24:0];
            if (op > 4) op = 4;
            nd  = d + 1;
            adv = 1'b1;
            case (op)
                0: exp_instr[d+1] = pl;
                1: nd = d + ((arg == 0) ? 1 : arg);
                2: begin
                    a7  = (arg >= 128);
                    thr = a7 ? (arg % 128) : arg;
                    if (thr == 0) thr = 1;
                    cnt = 0;
                    w   = d + 1;
                    while (1) begin
                        exp_instr[w] = pl;
                        if (a7 ? (vs1[w] || vs2[w]) : vs2[w]) cnt++;
                        if (cnt >= thr) begin
                            nd = w + 1;
                            break;
                        end
                        if (w - d == int'(TIMEOUT)) begin
                            exp_err = 1'b1;
                            exp_end = w + 1;
                            fin     = 1'b1;
                            adv     = 1'b0;
                            break;
                        end
                        w++;
                    end
                end
                3: begin
                    if (!la && arg != 0) begin
                        la  = 1'b1;
                        rem = arg - 1;
                        p   = int'(pl[ADDR_W-1:0]);
                        adv = 1'b0;
                    end else if (la && rem != 0) begin
                        rem--;
                        p   = int'(pl[ADDR_W-1:0]);
                        adv = 1'b0;
                    end else begin
                        la = 1'b0;
                    end
                end
                default: begin
                    exp_done_cyc = d + 1;
                    exp_end      = d + 1;
                    fin          = 1'b1;
                    adv          = 1'b0;
                end
            endcase
            if (adv) begin
                if (p == int'(DEPTH) - 1) begin
                    exp_done_cyc = nd;
                    exp_end      = nd;
                    fin          = 1'b1;
                end else begin
                    p++;
                end
            end
            d = nd;
            if (d > MAXC - 40) begin
                $display("FAIL model_bound: program ran past %0d cycles", MAXC - 40);
                $fatal(1, "model overrun");
            end
        end
        exp_pc = p;
        exp_la = la;
    endtask

    task automatic run_prog(input string name);
        model();
        load_all();
        start   = 1'b1;
        valid_1 = vs1[0];
        valid_2 = vs2[0];
        for (int c = 1; c <= exp_end + 1; c++) begin
            step();
            start = 1'b0;
            check_eq({name, " instr"}, 64'(instruction), 64'(exp_instr[c]));
            check_eq({name, " done"}, 64'(done), 64'(c == exp_done_cyc));
            check_eq({name, " busy"}, 64'(busy), 64'(c <= exp_end));
            valid_1 = vs1[c];
            valid_2 = vs2[c];
        end
        valid_1 = 1'b0;
        valid_2 = 1'b0;
        check_eq({name, " error"}, 64'(error), 64'(exp_err));
        check_eq({name, " pc"}, 64'(pc), 64'(exp_pc));
        check_eq({name, " loop_active"}, 64'(dut.loop_active_q), 64'(exp_la));
    endtask

    task automatic gen_random();
        int n;
        bit have_loop;
        clear_all();
        n = $urandom_range(2, 8);
        have_loop = 1'b0;
        for (int i = 0; i < n - 1; i++) begin
            int r;
            logic [PAYLOAD_W-1:0] pl;
            r  = $urandom_range(0, 9);
            pl = PAYLOAD_W'($urandom);
            if (r <= 3) begin
                prog[i] = mk(0, 0, pl);
            end else if (r <= 5) begin
                prog[i] = mk(1, $urandom_range(0, 4), pl);
            end else if (r <= 7) begin
                prog[i] = mk(2, $urandom_range(0, 3) + ($urandom_range(0, 1) * 128), pl);
            end else if (r == 8 && !have_loop && i > 0) begin
                have_loop = 1'b1;
                pl[ADDR_W-1:0] = ADDR_W'($urandom_range(0, i - 1));
                prog[i] = mk(3, $urandom_range(0, 3), pl);
            end else begin
                prog[i] = mk(0, 0, pl);
            end
        end
        prog[n-1] = mk($urandom_range(4, 7), $urandom_range(0, 255), PAYLOAD_W'($urandom));
        for (int c = 0; c < MAXC; c++) begin
            vs1[c] = ($urandom_range(0, 3) == 0);
            vs2[c] = ($urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        logic [ENTRY_W-1:0] newval;
        rst = 1'b1; start = 1'b0; abort = 1'b0; prog_we = 1'b0;
        prog_addr = '0; prog_wdata = '0; valid_1 = 1'b0; valid_2 = 1'b0;
        step(); step(); step();
        rst = 1'b0;
        step();
        check_eq("reset instr", 64'(instruction), 64'h0);
        check_eq("reset pc", 64'(pc), 64'h0);
        check_eq("reset busy", 64'(busy), 64'h0);
        check_eq("reset done", 64'(done), 64'h0);
        check_eq("reset error", 64'(error), 64'h0);

        // Two issues then halt.
        clear_all();
        prog[0] = mk(0, 0, 25'h0000AB);
        prog[1] = mk(0, 0, 25'h0000CD);
        run_prog("issue2");

        // Delay 3 and delay 0.
        clear_all();
        prog[0] = mk(1, 3, '0);
        prog[1] = mk(0, 0, 25'h1);
        run_prog("delay3");
        prog[0] = mk(1, 0, '0);
        run_prog("delay0");

        // Wait for two non-adjacent column-2 valids.
        clear_all();
        prog[0] = mk(2, 2, 25'h15);
        vs2[4] = 1'b1;
        vs2[7] = 1'b1;
        run_prog("wait2");

        // Wait with no valids: timeout.
        clear_all();
        prog[0] = mk(2, 2, 25'h15);
        run_prog("wait_tmo");

        // Loop: body issued three times.
        clear_all();
        prog[0] = mk(0, 0, 25'h2);
        prog[1] = mk(3, 2, '0);
        run_prog("loop");

        // Jump to the end of memory and run off the last entry.
        clear_all();
        prog[0]  = mk(3, 1, 25'h1FFFFFE);
        prog[30] = mk(0, 0, 25'h7);
        prog[31] = mk(0, 0, 25'h9);
        run_prog("wrap");

        for (int k = 0; k < 25; k++) begin
            gen_random();
            run_prog($sformatf("rand%0d", k));
        end

        // Abort in the middle of a delay.
        clear_all();
        prog[0] = mk(1, 10, '0);
        load_all();
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_eq("abort instr", 64'(instruction), 64'h0);
        check_eq("abort busy", 64'(busy), 64'h0);
        for (int c = 0; c < 12; c++) begin
            check_eq("abort done", 64'(done), 64'h0);
            step();
        end
        check_eq("abort idle", 64'(busy), 64'h0);

        // Reset in the middle of a wait.
        clear_all();
        prog[0] = mk(0, 0, 25'h33);
        prog[1] = mk(2, 2, 25'h15);
        load_all();
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step(); step();
        check_eq("rst pre instr", 64'(instruction), 64'h15);
        check_eq("rst pre pc", 64'(pc), 64'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rst instr", 64'(instruction), 64'h0);
        check_eq("rst pc", 64'(pc), 64'h0);
        check_eq("rst busy", 64'(busy), 64'h0);
        check_eq("rst done", 64'(done), 64'h0);
        check_eq("rst error", 64'(error), 64'h0);
        check_eq("rst loop_active", 64'(dut.loop_active_q), 64'h0);

        // Program writes while busy are dropped; writes while idle land next cycle.
        clear_all();
        prog[0] = mk(1, 20, '0);
        prog[5] = mk(0, 0, 25'h0055AA);
        load_all();
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        prog_we    = 1'b1;
        prog_addr  = ADDR_W'(5);
        prog_wdata = mk(0, 0, 25'h1ABCDE);
        step();
        prog_we = 1'b0;
        for (int c = 0; c < 24; c++) step();
        check_eq("we_busy idle", 64'(busy), 64'h0);
        check_eq("we_busy mem", 64'(dut.u_prog_mem.mem_q[5]), 64'(prog[5]));
        newval     = mk(2, 7, 25'h0F0F0F);
        prog_we    = 1'b1;
        prog_addr  = ADDR_W'(5);
        prog_wdata = newval;
        step();
        prog_we = 1'b0;
        check_eq("we_idle mem", 64'(dut.u_prog_mem.mem_q[5]), 64'(newval));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
